// File: rtl/pipe_stage_skid.sv
// Purpose : generic pipeline stage register (payload + control) with valid/ready, freeze, flush and optional skid entry.
// Latency : 1 cycle in->out; 1 transfer/cycle sustained while out_ready is high.
// Backpressure: SKID_EN=1 registers in_ready (deasserts only when the skid entry is occupied); SKID_EN=0 passes out_ready through combinationally.
//
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-high reset
//   flush               - synchronous squash of every held entry (priority over all else)
//   freeze              - hazard stall: blocks both handshakes, state held
//   in_valid/in_ready   - upstream handshake, in_payload/in_ctrl carried with it
//   out_valid/out_ready - downstream handshake, out_payload/out_ctrl from the main entry
//   occupancy           - number of valid entries held (0..2)
//   squash_count        - saturating count of flushes that killed at least one valid entry

module pipe_stage_skid #(
   parameter int unsigned PAYLOAD_WIDTH    = 128,
   parameter int unsigned CTRL_WIDTH       = 8,
   parameter int unsigned SKID_EN          = 1,
   parameter int unsigned FLUSH_CLEAR_DATA = 0,
   parameter int unsigned CNT_WIDTH        = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     freeze,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PAYLOAD_WIDTH-1:0] in_payload,
   input  logic [CTRL_WIDTH-1:0]    in_ctrl,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PAYLOAD_WIDTH-1:0] out_payload,
   output logic [CTRL_WIDTH-1:0]    out_ctrl,
   output logic [1:0]               occupancy,
   output logic [CNT_WIDTH-1:0]     squash_count
);

   // One stored pipeline entry: opaque data plus control bits that must read
   // as zero whenever the entry is a bubble.
   typedef struct packed {
      logic [PAYLOAD_WIDTH-1:0] payload;
      logic [CTRL_WIDTH-1:0]    ctrl;
   } entry_t;

   logic                 main_valid_q, main_valid_d;
   logic                 skid_valid_q, skid_valid_d;
   entry_t               main_q, main_d;
   entry_t               skid_q, skid_d;
   logic [CNT_WIDTH-1:0] squash_cnt_q, squash_cnt_d;

   entry_t in_entry;
   logic   accept;
   logic   take;

   assign in_entry.payload = in_payload;
   assign in_entry.ctrl    = in_ctrl;

   // ------------------------------------------------------------------
   // Handshake signals
   // ------------------------------------------------------------------
   // Flush and freeze both hide the main entry from downstream so that no
   // transfer can complete on a cycle whose state is being held or killed.
   assign out_valid = main_valid_q & ~freeze & ~flush;
   assign take      = out_valid & out_ready;

   // With the skid entry present, in_ready depends only on the registered
   // skid_valid_q: a second beat arriving while downstream stalls lands in
   // the skid entry, so there is no out_ready -> in_ready timing path.
   // Without it, a full stage can only accept if the main entry leaves in
   // the same cycle. rst gates in_ready so nothing is offered as accepted
   // while the stage is held in reset.
   always_comb begin
      in_ready = 1'b0;
      if (SKID_EN != 0) begin
         in_ready = ~skid_valid_q;
      end else begin
         in_ready = ~main_valid_q | out_ready;
      end
      in_ready = in_ready & ~freeze & ~flush & ~rst;
   end

   assign accept = in_valid & in_ready;

   // ------------------------------------------------------------------
   // Entry next-state
   // ------------------------------------------------------------------
   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;

      if (flush) begin
         // Control bits are cleared so a squashed entry can never fire
         // side effects later; payload is kept unless explicitly cleared.
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         main_d.ctrl  = '0;
         skid_d.ctrl  = '0;
         if (FLUSH_CLEAR_DATA != 0) begin
            main_d.payload = '0;
            skid_d.payload = '0;
         end
      end else if (SKID_EN != 0) begin
         // freeze needs no branch of its own: it forces accept and take low,
         // which leaves every register at its hold value.
         if (take) begin
            if (skid_valid_q) begin
               // FULL: in_ready is low, so only the skid -> main move happens.
               main_d       = skid_q;
               skid_valid_d = 1'b0;
            end else if (accept) begin
               main_d = in_entry;
            end else begin
               main_valid_d = 1'b0;
            end
         end else if (accept) begin
            if (main_valid_q) begin
               // Downstream stalled with main occupied: park the beat.
               skid_d       = in_entry;
               skid_valid_d = 1'b1;
            end else begin
               main_d       = in_entry;
               main_valid_d = 1'b1;
            end
         end
      end else begin
         if (accept) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
         end else if (take) begin
            main_valid_d = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Squash counter: counts only flushes that actually killed work.
   // ------------------------------------------------------------------
   always_comb begin
      squash_cnt_d = squash_cnt_q;
      if (flush && (occupancy != 2'd0) && (squash_cnt_q != {CNT_WIDTH{1'b1}})) begin
         squash_cnt_d = squash_cnt_q + CNT_WIDTH'(1);
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
         squash_cnt_q <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
         squash_cnt_q <= squash_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign out_payload  = main_q.payload;
   assign out_ctrl     = main_q.ctrl & {CTRL_WIDTH{out_valid}};
   assign occupancy    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   assign squash_count = squash_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios on a skid instance and a
// no-skid/clear-on-flush/2-bit-counter instance, then randomized traffic on
// both, checked against a queue-based model of the stage.
module tb_pipe_stage_skid;

   typedef struct packed {
      logic [127:0] pay;
      logic [7:0]   ctrl;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance A: defaults (skid, payload held on flush, 16-bit counter)
   logic         a_flush, a_freeze, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [127:0] a_in_payload, a_out_payload;
   logic [7:0]   a_in_ctrl, a_out_ctrl;
   logic [1:0]   a_occupancy;
   logic [15:0]  a_squash_count;

   // instance B: no skid, payload cleared on flush, 2-bit counter
   logic         b_flush, b_freeze, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [127:0] b_in_payload, b_out_payload;
   logic [7:0]   b_in_ctrl, b_out_ctrl;
   logic [1:0]   b_occupancy;
   logic [1:0]   b_squash_count;

   int n_cmp = 0;
   int n_err = 0;

   pipe_stage_skid dut_a (
      .clk(clk), .rst(rst), .flush(a_flush), .freeze(a_freeze),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_payload(a_in_payload), .in_ctrl(a_in_ctrl),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_payload(a_out_payload), .out_ctrl(a_out_ctrl),
      .occupancy(a_occupancy), .squash_count(a_squash_count)
   );

   pipe_stage_skid #(.SKID_EN(0), .FLUSH_CLEAR_DATA(1), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .flush(b_flush), .freeze(b_freeze),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_payload(b_in_payload), .in_ctrl(b_in_ctrl),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_payload(b_out_payload), .out_ctrl(b_out_ctrl),
      .occupancy(b_occupancy), .squash_count(b_squash_count)
   );

   // Quiesce both instances and let any held entries drain; ends on a negedge.
   task automatic drain();
      a_in_valid = 0; a_out_ready = 1; a_freeze = 0; a_flush = 0;
      b_in_valid = 0; b_out_ready = 1; b_freeze = 0; b_flush = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      a_in_valid = 1; a_in_payload = 128'h99;
      #1;
      n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %0b want 0", a_in_ready); end
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", a_out_valid); end
      n_cmp++; if (a_occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occupancy: got %0d want 0", a_occupancy); end
      n_cmp++; if (a_squash_count !== 16'd0) begin n_err++; $display("FAIL rst_squash: got %0d want 0", a_squash_count); end
      n_cmp++; if (a_out_payload !== 128'd0) begin n_err++; $display("FAIL rst_payload: got %0h want 0", a_out_payload); end
      n_cmp++; if (a_out_ctrl !== 8'd0) begin n_err++; $display("FAIL rst_ctrl: got %0h want 0", a_out_ctrl); end
      n_cmp++; if (b_occupancy !== 2'd0) begin n_err++; $display("FAIL rst_b_occupancy: got %0d want 0", b_occupancy); end
      // fill A to two entries, then hit reset mid-cycle
      rst = 0; a_out_ready = 0; a_in_payload = 128'h1;
      @(negedge clk); a_in_payload = 128'h2;
      @(negedge clk); a_in_valid = 0;
      #1;
      n_cmp++; if (a_occupancy !== 2'd2) begin n_err++; $display("FAIL rst_prefill_occ: got %0d want 2", a_occupancy); end
      #1 rst = 1;
      #1;
      n_cmp++; if (a_occupancy !== 2'd0) begin n_err++; $display("FAIL rst_async_occ: got %0d want 0", a_occupancy); end
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %0b want 0", a_out_valid); end
      n_cmp++; if (a_squash_count !== 16'd0) begin n_err++; $display("FAIL rst_async_squash: got %0d want 0", a_squash_count); end
      @(negedge clk);
      rst = 0; a_in_valid = 1; a_in_payload = 128'h55; a_in_ctrl = 8'h12;
      #1;
      n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %0b want 1", a_in_ready); end
      @(negedge clk); a_in_valid = 0;
      #1;
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_payload !== 128'h55) begin
         n_err++; $display("FAIL rst_first_accept: got v=%0b p=%0h want v=1 p=55", a_out_valid, a_out_payload); end
      n_cmp++; if (a_occupancy !== 2'd1) begin n_err++; $display("FAIL rst_first_occ: got %0d want 1", a_occupancy); end
      drain();
   endtask

   task automatic test_streaming();
      a_out_ready = 1; a_in_ctrl = 8'h0F;
      for (int i = 1; i <= 8; i++) begin
         a_in_valid = 1; a_in_payload = 128'(i);
         #1;
         n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %0b want 1", i, a_in_ready); end
         if (i > 1) begin
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_payload !== 128'(i - 1)) begin
               n_err++; $display("FAIL stream_out[%0d]: got v=%0b p=%0h want v=1 p=%0h", i, a_out_valid, a_out_payload, i - 1); end
         end
         @(negedge clk);
      end
      a_in_valid = 0;
      #1;
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_payload !== 128'h8) begin
         n_err++; $display("FAIL stream_last: got v=%0b p=%0h want v=1 p=8", a_out_valid, a_out_payload); end
      @(negedge clk);
      n_cmp++; if (a_occupancy !== 2'd0) begin n_err++; $display("FAIL stream_drained: got %0d want 0", a_occupancy); end
      drain();
   endtask

   task automatic test_backpressure();
      a_out_ready = 0; a_in_valid = 1; a_in_payload = 128'hA;
      @(negedge clk); a_in_payload = 128'hB;
      #1;
      n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_one: got %0b want 1", a_in_ready); end
      @(negedge clk); a_in_valid = 0;
      #1;
      n_cmp++; if (a_occupancy !== 2'd2 || a_in_ready !== 1'b0) begin
         n_err++; $display("FAIL bp_full: got occ=%0d rdy=%0b want occ=2 rdy=0", a_occupancy, a_in_ready); end
      n_cmp++; if (a_out_payload !== 128'hA) begin n_err++; $display("FAIL bp_head: got %0h want A", a_out_payload); end
      a_out_ready = 1;
      @(negedge clk);
      #1;
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_payload !== 128'hB || a_occupancy !== 2'd1) begin
         n_err++; $display("FAIL bp_second: got v=%0b p=%0h occ=%0d want v=1 p=B occ=1", a_out_valid, a_out_payload, a_occupancy); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %0b want 1", a_in_ready); end
      @(negedge clk);
      n_cmp++; if (a_occupancy !== 2'd0) begin n_err++; $display("FAIL bp_drained: got %0d want 0", a_occupancy); end
      drain();
   endtask

   task automatic test_flush();
      a_out_ready = 0; a_in_ctrl = 8'hFF; a_in_valid = 1; a_in_payload = 128'hA;
      @(negedge clk); a_in_payload = 128'hB;
      @(negedge clk); a_flush = 1; a_in_payload = 128'hC;
      #1;
      n_cmp++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00) begin
         n_err++; $display("FAIL flush_during: got rdy=%0b v=%0b c=%0h want 0/0/00", a_in_ready, a_out_valid, a_out_ctrl); end
      @(negedge clk); a_flush = 0; a_in_valid = 0;
      #1;
      n_cmp++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00 || a_occupancy !== 2'd0) begin
         n_err++; $display("FAIL flush_after: got v=%0b c=%0h occ=%0d want 0/00/0", a_out_valid, a_out_ctrl, a_occupancy); end
      n_cmp++; if (a_squash_count !== 16'd1) begin n_err++; $display("FAIL flush_count: got %0d want 1", a_squash_count); end
      n_cmp++; if (a_out_payload !== 128'hA) begin n_err++; $display("FAIL flush_payload_held: got %0h want A", a_out_payload); end
      a_flush = 1;
      @(negedge clk); a_flush = 0;
      #1;
      n_cmp++; if (a_squash_count !== 16'd1) begin n_err++; $display("FAIL flush_empty_count: got %0d want 1", a_squash_count); end
      drain();
   endtask

   task automatic test_freeze();
      a_out_ready = 0; a_in_valid = 1; a_in_payload = 128'h77; a_in_ctrl = 8'h5A;
      @(negedge clk);
      a_freeze = 1; a_out_ready = 1; a_in_payload = 128'h99;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_occupancy !== 2'd1 || a_out_ctrl !== 8'h0) begin
            n_err++; $display("FAIL freeze_hold[%0d]: got v=%0b rdy=%0b occ=%0d c=%0h want 0/0/1/0", k, a_out_valid, a_in_ready, a_occupancy, a_out_ctrl); end
         @(negedge clk);
      end
      a_freeze = 0; a_in_valid = 0;
      #1;
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_payload !== 128'h77 || a_out_ctrl !== 8'h5A) begin
         n_err++; $display("FAIL freeze_release: got v=%0b p=%0h c=%0h want 1/77/5A", a_out_valid, a_out_payload, a_out_ctrl); end
      @(negedge clk);
      n_cmp++; if (a_occupancy !== 2'd0) begin n_err++; $display("FAIL freeze_drained: got %0d want 0", a_occupancy); end
      drain();
   endtask

   task automatic test_noskid();
      b_out_ready = 0; b_in_valid = 1; b_in_payload = 128'h11; b_in_ctrl = 8'h3C;
      @(negedge clk); b_in_payload = 128'h22;
      #1;
      n_cmp++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL ns_full_ready: got %0b want 0", b_in_ready); end
      b_out_ready = 1;
      #1;
      n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL ns_pass_ready: got %0b want 1", b_in_ready); end
      @(negedge clk); b_in_valid = 0; b_flush = 1;
      #1;
      n_cmp++; if (b_out_payload !== 128'h22 || b_occupancy !== 2'd1) begin
         n_err++; $display("FAIL ns_replace: got p=%0h occ=%0d want 22/1", b_out_payload, b_occupancy); end
      @(negedge clk); b_flush = 0;
      #1;
      n_cmp++; if (b_out_payload !== 128'd0 || b_occupancy !== 2'd0 || b_squash_count !== 2'd1) begin
         n_err++; $display("FAIL ns_flush: got p=%0h occ=%0d cnt=%0d want 0/0/1", b_out_payload, b_occupancy, b_squash_count); end
      for (int k = 2; k <= 5; k++) begin
         b_out_ready = 0; b_in_valid = 1; b_in_payload = 128'(k);
         @(negedge clk); b_in_valid = 0; b_flush = 1;
         @(negedge clk); b_flush = 0;
         #1;
         n_cmp++; if (b_squash_count !== 2'((k > 3) ? 3 : k)) begin
            n_err++; $display("FAIL ns_sat[%0d]: got %0d want %0d", k, b_squash_count, (k > 3) ? 3 : k); end
      end
      drain();
   endtask

   // Randomized traffic: the model is a FIFO of capacity cap (2 with skid, 1
   // without, where a same-cycle departure frees the slot).
   task automatic test_random(input bit use_b, input int cycles);
      ent_t q[$];
      int   cnt = 0;
      int   cnt_max = use_b ? 3 : 65535;
      bit   iv, ordy, frz, fl, exp_ir, exp_ov;
      ent_t e;
      rst = 1;
      @(negedge clk); rst = 0;
      for (int c = 0; c < cycles; c++) begin
         iv = ($urandom % 4) != 0; ordy = ($urandom % 3) != 0;
         frz = ($urandom % 8) == 0; fl = ($urandom % 16) == 0;
         e.pay = {$urandom, $urandom, $urandom, $urandom}; e.ctrl = 8'($urandom);
         if (use_b) begin
            b_in_valid = iv; b_out_ready = ordy; b_freeze = frz; b_flush = fl; b_in_payload = e.pay; b_in_ctrl = e.ctrl;
         end else begin
            a_in_valid = iv; a_out_ready = ordy; a_freeze = frz; a_flush = fl; a_in_payload = e.pay; a_in_ctrl = e.ctrl;
         end
         exp_ov = (q.size() > 0) && !frz && !fl;
         exp_ir = (use_b ? (q.size() == 0 || ordy) : (q.size() < 2)) && !frz && !fl;
         #1;
         n_cmp++;
         if ((use_b ? b_in_ready : a_in_ready) !== exp_ir || (use_b ? b_out_valid : a_out_valid) !== exp_ov ||
             (use_b ? b_occupancy : a_occupancy) !== 2'(q.size())) begin
            n_err++; $display("FAIL rnd%s_hs[%0d]: got rdy=%0b v=%0b occ=%0d want %0b/%0b/%0d", use_b ? "B" : "A", c,
                              use_b ? b_in_ready : a_in_ready, use_b ? b_out_valid : a_out_valid,
                              use_b ? b_occupancy : a_occupancy, exp_ir, exp_ov, q.size());
         end
         n_cmp++;
         if ((use_b ? 16'(b_squash_count) : a_squash_count) !== 16'(cnt)) begin
            n_err++; $display("FAIL rnd%s_cnt[%0d]: got %0d want %0d", use_b ? "B" : "A", c,
                              use_b ? 16'(b_squash_count) : a_squash_count, cnt);
         end
         n_cmp++;
         if (exp_ov) begin
            if ((use_b ? b_out_payload : a_out_payload) !== q[0].pay || (use_b ? b_out_ctrl : a_out_ctrl) !== q[0].ctrl) begin
               n_err++; $display("FAIL rnd%s_data[%0d]: got p=%0h c=%0h want p=%0h c=%0h", use_b ? "B" : "A", c,
                                 use_b ? b_out_payload : a_out_payload, use_b ? b_out_ctrl : a_out_ctrl, q[0].pay, q[0].ctrl);
            end
         end else if ((use_b ? b_out_ctrl : a_out_ctrl) !== 8'h00) begin
            n_err++; $display("FAIL rnd%s_bubble_ctrl[%0d]: got %0h want 00", use_b ? "B" : "A", c, use_b ? b_out_ctrl : a_out_ctrl);
         end
         // model update for the coming edge
         if (fl) begin
            if (q.size() > 0 && cnt < cnt_max) cnt++;
            q.delete();
         end else begin
            if (exp_ov && ordy) void'(q.pop_front());
            if (exp_ir && iv) q.push_back(e);
         end
         @(negedge clk);
      end
      drain();
   endtask

   initial begin
      rst = 1;
      a_flush = 0; a_freeze = 0; a_in_valid = 0; a_out_ready = 0; a_in_payload = '0; a_in_ctrl = '0;
      b_flush = 0; b_freeze = 0; b_in_valid = 0; b_out_ready = 0; b_in_payload = '0; b_in_ctrl = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_freeze();
      test_noskid();
      test_random(1'b0, 600);
      test_random(1'b1, 600);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
